// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the seven-segment scanner.
package seg7_pkg;

  typedef enum logic {
    StGuard = 1'b0,
    StDrive = 1'b1
  } state_e;

  // Segment bit order is {g, f, e, d, c, b, a}; 1 = segment lit before polarity inversion.
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_ALL = 7'b1111111;

  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; polarity is applied by the scanner.
  always_comb begin
    seg_o = hex_to_seg(nib_i);
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver with guard interval, per-digit enable,
// decimal points and leading-zero blanking.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES    = 50000,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned MaxCycles = (SLOT_CYCLES > GUARD_CYCLES) ? SLOT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles);
  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] SlotLast   = CntW'(SLOT_CYCLES - 1);
  localparam logic [CntW-1:0] SlotPenult = CntW'(SLOT_CYCLES - 2);
  localparam logic [CntW-1:0] GuardLast  = CntW'(GUARD_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast    = IdxW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] sh_value_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q;
  logic                    sh_lz_q;

  logic [4*NUM_DIGITS-1:0] cur_value;
  logic [NUM_DIGITS-1:0]   cur_dp, cur_en;
  logic                    cur_lz;

  logic [NUM_DIGITS-1:0]   keep;
  logic                    nz_seen;
  logic [3:0]              sel_nib;
  logic                    sel_dp, sel_en, sel_keep, blank;
  logic [6:0]              enc_seg;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  // Shadow registers capture the display request on a load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value_q <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      sh_lz_q    <= 1'b0;
    end else if (load) begin
      sh_value_q <= value;
      sh_dp_q    <= dp_in;
      sh_en_q    <= digit_en;
      sh_lz_q    <= lz_blank;
    end
  end

  // Bypass so a load on the DRIVE-entry edge is already visible to that slot.
  always_comb begin
    cur_value = load ? value    : sh_value_q;
    cur_dp    = load ? dp_in    : sh_dp_q;
    cur_en    = load ? digit_en : sh_en_q;
    cur_lz    = load ? lz_blank : sh_lz_q;
  end

  // Prefix-OR from the MSB digit: a digit is kept once any digit at or above it is non-zero
  // or requests a decimal point. Digit 0 is always kept.
  always_comb begin
    keep    = '0;
    nz_seen = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nz_seen = nz_seen | (cur_value[4*i +: 4] != 4'h0) | cur_dp[i];
      keep[i] = nz_seen;
    end
    keep[0] = 1'b1;
  end

  // Select the nibble and flags of the digit about to be driven.
  always_comb begin
    sel_nib  = 4'h0;
    sel_dp   = 1'b0;
    sel_en   = 1'b0;
    sel_keep = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_nib  = cur_value[4*i +: 4];
        sel_dp   = cur_dp[i];
        sel_en   = cur_en[i];
        sel_keep = keep[i];
      end
    end
    blank = !sel_en || (cur_lz && !sel_keep);
  end

  seg7_hex_encode u_encode (
    .nib_i (sel_nib),
    .seg_o (enc_seg)
  );

  // State register: FSM state, cycle counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StGuard;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: count each phase to its limit, advance the index when a slot ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    unique case (state_q)
      StGuard: begin
        if (cnt_q == GuardLast) begin
          state_d = StDrive;
          cnt_d   = '0;
        end
      end
      StDrive: begin
        if (cnt_q == SlotLast) begin
          state_d = StGuard;
          cnt_d   = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
      end
    endcase
  end

  // Output next-values: load on DRIVE entry, hold through the slot, otherwise off.
  // frame_done is set one cycle early so the registered pulse lands on the slot's last cycle.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    an_d  = '0;
    if (state_q == StGuard && cnt_q == GuardLast) begin
      seg_d = blank ? SEG_OFF : enc_seg;
      dp_d  = sel_dp && sel_en;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        an_d[i] = (idx_q == IdxW'(i));
      end
    end else if (state_q == StDrive && cnt_q != SlotLast) begin
      seg_d = seg_q;
      dp_d  = dp_q;
      an_d  = an_q;
    end
    frame_done_d = (state_q == StDrive) && (cnt_q == SlotPenult) && (idx_q == IdxLast);
  end

  // Output registers hold active-high levels; reset forces everything off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = SEG_ACTIVE_LOW ? (seg_q ^ SEG_ALL) : seg_q;
  assign dp         = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
  assign an         = AN_ACTIVE_LOW ? ~an_q : an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized self-checking bench for seven_segment_scanner against a cycle-position model.
module tb_seven_segment_scanner;

  localparam int N = 4;
  localparam int S = 4;
  localparam int G = 2;
  localparam int P = S + G;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_segment_scanner #(
    .NUM_DIGITS     (N),
    .SLOT_CYCLES    (S),
    .GUARD_CYCLES   (G),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: m_k counts clock edges since reset release; position within the frame is derived
  // arithmetically from it.
  int          m_k;
  logic [15:0] m_v;
  logic [3:0]  m_dp, m_en;
  logic        m_lz;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at k=%0d: got %0h expected %0h", tag, m_k, got, exp);
  endtask

  task automatic model_reset();
    m_k   = 0;
    m_v   = '0;
    m_dp  = '0;
    m_en  = '0;
    m_lz  = 1'b0;
    e_seg = 7'b0;
    e_dp  = 1'b0;
    e_an  = 4'hF;
    e_fd  = 1'b0;
  endtask

  task automatic model_edge();
    int         o, slot;
    logic [3:0] nib;
    logic       upper_zero, blank;
    if (load) begin
      m_v  = value;
      m_dp = dp_in;
      m_en = digit_en;
      m_lz = lz_blank;
    end
    m_k++;
    o    = m_k % P;
    slot = (m_k / P) % N;
    if (o == G) begin
      nib        = m_v[4*slot +: 4];
      upper_zero = ((m_v >> (4 * slot)) == 16'h0) && ((m_dp >> slot) == 4'h0);
      blank      = !m_en[slot] || (m_lz && slot != 0 && upper_zero);
      e_seg      = blank ? 7'b0 : glyph(nib);
      e_dp       = m_dp[slot] && m_en[slot];
      e_an       = ~(4'b0001 << slot);
    end else if (o < G) begin
      e_seg = 7'b0;
      e_dp  = 1'b0;
      e_an  = 4'hF;
    end
    e_fd = (slot == N - 1) && (o == P - 1);
  endtask

  task automatic check_outputs();
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                         input logic lz);
    value    = v;
    dp_in    = d;
    digit_en = e;
    lz_blank = lz;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Step until the model is mid-way through the given digit's drive slot.
  task automatic wait_mid_slot(input int digit);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * N * P && !found; i++) begin
      step();
      if (((m_k / P) % N) == digit && (m_k % P) == G + 1) found = 1'b1;
    end
    check_eq("wait_mid_slot", 32'(found), 32'd1);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_load(rand_value(),
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
                1'($urandom));
      end else begin
        step();
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    value    = '0;
    dp_in    = '0;
    digit_en = '0;
    lz_blank = 1'b0;
    load     = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Plain hex, all digits enabled.
    do_load(16'h12AF, 4'h0, 4'hF, 1'b0);
    run(2 * N * P);

    // Leading-zero blanking cases.
    do_load(16'h0050, 4'h0, 4'hF, 1'b1);
    run(N * P);
    do_load(16'h0000, 4'h0, 4'hF, 1'b1);
    run(N * P);
    do_load(16'h0000, 4'b0100, 4'hF, 1'b1);
    run(N * P);

    // Loads landing mid-slot must not disturb the digit being driven.
    do_load(16'h1111, 4'h0, 4'hF, 1'b0);
    wait_mid_slot(1);
    do_load(16'h2222, 4'h0, 4'hF, 1'b0);
    run(N * P);

    random_phase(600);

    // Asynchronous reset in the middle of a drive slot.
    wait_mid_slot(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("an_async_off", 32'(an), 32'hF);
    check_eq("seg_async_off", 32'(seg), 32'h0);
    check_eq("dp_async_off", 32'(dp), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    run(N * P);
    random_phase(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
